// File: rtl/mips_pkg.sv
// Shared constants and types for the 3-stage MIPS32 datapath and its instruction-side
// sequencer.
package mips_pkg;

    localparam logic [5:0] OP_RFORMAT = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b000011;
    localparam logic [5:0] OP_SUBI    = 6'b000010;
    localparam logic [5:0] OP_XORI    = 6'b000001;
    localparam logic [5:0] OP_ANDI    = 6'b001111;
    localparam logic [5:0] OP_ORI     = 6'b001100;

    localparam logic [5:0] FUNC_ADD = 6'b000011;
    localparam logic [5:0] FUNC_SUB = 6'b000010;
    localparam logic [5:0] FUNC_XOR = 6'b000001;
    localparam logic [5:0] FUNC_AND = 6'b000111;
    localparam logic [5:0] FUNC_OR  = 6'b000100;

    // SUB R0,R0,R0: a bubble that writes nothing architecturally visible.
    localparam logic [31:0] NOP_WORD = 32'h0000_0002;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/ifetch_imem.sv
// Instruction store: synchronous write, asynchronous read, contents never cleared.
module ifetch_imem #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ifetch_sequencer.sv
// Instruction-side producer: fetches one word per unstalled clock onto ibus, honours
// redirects, then drains the pipeline with NOPs and raises done.
module ifetch_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    output logic [31:0]   ibus,
    output logic [AW-1:0] pc,
    output logic          fetch_valid,
    output logic          done
);

    localparam int unsigned CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [AW:0]   DepthLen  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] DrainInit = CW'(DRAIN_CYCLES);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   ibus_q, ibus_d;
    logic          fv_q, fv_d;
    logic          done_q, done_d;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    ifetch_imem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ibus_d  = ibus_q;
        fv_d    = fv_q;
        done_d  = done_q;
        mem_we  = 1'b0;

        unique case (state_q)
            StIdle, StHalt: begin
                ibus_d = NOP_WORD;
                fv_d   = 1'b0;
                mem_we = load_en;
                if (start && (prog_len != '0) && (prog_len <= DepthLen)) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    done_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (redirect_valid) begin
                    pc_d   = redirect_addr;
                    ibus_d = NOP_WORD;
                    fv_d   = 1'b0;
                end else if (!stall) begin
                    // A redirect past the program end drains without fetching.
                    if ({1'b0, pc_q} >= len_q) begin
                        ibus_d  = NOP_WORD;
                        fv_d    = 1'b0;
                        cnt_d   = DrainInit;
                        state_d = StDrain;
                    end else begin
                        ibus_d = mem_rdata;
                        fv_d   = 1'b1;
                        pc_d   = pc_q + 1'b1;
                        if ({1'b0, pc_q} == len_q - 1'b1) begin
                            cnt_d   = DrainInit;
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if (!stall) begin
                    ibus_d = NOP_WORD;
                    fv_d   = 1'b0;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = StHalt;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ibus_q  <= NOP_WORD;
            fv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ibus_q  <= ibus_d;
            fv_q    <= fv_d;
            done_q  <= done_d;
        end
    end

    assign ibus        = ibus_q;
    assign pc          = pc_q;
    assign fetch_valid = fv_q;
    assign done        = done_q;

endmodule
